cpu_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the 16-bit RISC core. It owns the program counter and fetches instructions over a req/ack instruction-memory port. It decodes the 5-bit opcode and drives the register-file select and write ports plus the ALU start/done handshake, one instruction at a time. It replaces the single-cycle decode path as the block that sequences the datapath.

---
 rtl/cpu_sequencer.sv | 175 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: owns the PC, fetches over a req/ack port and
// steps the register file / ALU handshake. Optional trap: CPU_SEQUENCER_ILLEGAL_TRAP_EN.
module cpu_sequencer #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic [2:0]      reg_sel_r0,
  output logic [2:0]      reg_sel_r1,
  output logic [2:0]      reg_sel_w0,
  output logic            reg_w0_rw,
  input  logic [15:0]     reg_r0_data,
  output logic [4:0]      alu_op,
  output logic            alu_start,
  input  logic            alu_done,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            illegal_op
);

  typedef enum logic [2:0] {
    ST_START,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CL_RTYPE,
    CL_BEQZ,
    CL_JMP,
    CL_HALT,
    CL_ILLEGAL
  } op_class_t;

  localparam logic [4:0] OP_BEQZ = 5'b01000;
  localparam logic [4:0] OP_JMP  = 5'b01001;
  localparam logic [4:0] OP_HALT = 5'b11111;

  state_t          state, next_state;
  op_class_t       op_class;
  logic [15:0]     ir;
  logic [PC_W-1:0] pc_q, pc_next, pc_inc, pc_branch, pc_jump;

  logic [4:0] opcode;
  logic [2:0] ra, rb, rc;

  assign opcode = ir[15:11];
  assign ra     = ir[10:8];
  assign rb     = ir[7:5];
  assign rc     = ir[4:2];

  assign pc        = pc_q;
  assign imem_addr = pc_q;

  // Targets are taken modulo 2^PC_W; since PC_W <= 8, sign-extending imm8 beyond
  // PC_W bits cannot change the truncated sum, so the low PC_W bits suffice.
  assign pc_inc    = pc_q + PC_W'(1);
  assign pc_branch = pc_inc + ir[PC_W-1:0];
  assign pc_jump   = ir[PC_W-1:0];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    op_class = CL_ILLEGAL;
    if (opcode[4:3] == 2'b00)   op_class = CL_RTYPE;
    else if (opcode == OP_BEQZ) op_class = CL_BEQZ;
    else if (opcode == OP_JMP)  op_class = CL_JMP;
    else if (opcode == OP_HALT) op_class = CL_HALT;
  end

  always_comb begin
    next_state = state;
    pc_next    = pc_q;
    unique case (state)
      ST_START:  next_state = ST_FETCH;
      ST_FETCH:  if (imem_ack) next_state = ST_DECODE;
      ST_DECODE: begin
        unique case (op_class)
          CL_RTYPE, CL_BEQZ, CL_JMP: next_state = ST_EXEC;
          CL_HALT:                   next_state = ST_HALT;
          default: begin
`ifdef CPU_SEQUENCER_ILLEGAL_TRAP_EN
            next_state = ST_HALT;
`else
            next_state = ST_WB;
`endif
          end
        endcase
      end
      ST_EXEC: begin
        if (op_class == CL_RTYPE) begin
          if (alu_done) next_state = ST_WB;
        end else begin
          next_state = ST_FETCH;
          if (op_class == CL_JMP)    pc_next = pc_jump;
          else if (reg_r0_data == '0) pc_next = pc_branch;
          else                        pc_next = pc_inc;
        end
      end
      ST_WB: begin
        next_state = ST_FETCH;
        pc_next    = pc_inc;
      end
      ST_HALT:   next_state = ST_HALT;
      default:   next_state = ST_START;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_START;
      pc_q  <= '0;
      // NOTE: IR is a single architectural register, not a memory array, so it
      // is reset like everything else and decodes as a defined word after reset.
      ir    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      state <= next_state;
      pc_q  <= pc_next;
      if (state == ST_FETCH && imem_ack) ir <= imem_rdata;
    end
  end

  // Registered outputs are computed from the upcoming state so each one is
  // valid in the very cycle its state is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_req   <= 1'b0;
      alu_start  <= 1'b0;
      reg_w0_rw  <= 1'b0;
      halted     <= 1'b0;
      alu_op     <= '0;
      reg_sel_r0 <= '0;
      reg_sel_r1 <= '0;
      reg_sel_w0 <= '0;
    end else begin
      imem_req  <= (next_state == ST_FETCH);
      alu_start <= (state == ST_DECODE) && (next_state == ST_EXEC) &&
                   (op_class == CL_RTYPE);
      reg_w0_rw <= (state == ST_EXEC) && (next_state == ST_WB);
      halted    <= (next_state == ST_HALT);
      if (state == ST_DECODE) begin
        alu_op <= opcode;
        if (op_class == CL_RTYPE) begin
          reg_sel_w0 <= ra;
          reg_sel_r0 <= rb;
          reg_sel_r1 <= rc;
        end else if (op_class == CL_BEQZ) begin
          reg_sel_r0 <= ra;
        end
      end
    end
  end

`ifdef CPU_SEQUENCER_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_op <= 1'b0;
    end else if (state == ST_DECODE && op_class == CL_ILLEGAL) begin
      illegal_op <= 1'b1;
    end
  end
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer: reset, R-type, stalls, branches,
// PC wrap, illegal opcode, mid-WB reset and HALT.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [2:0]  reg_sel_r0, reg_sel_r1, reg_sel_w0;
  logic        reg_w0_rw;
  logic [15:0] reg_r0_data;
  logic [4:0]  alu_op;
  logic        alu_start;
  logic        alu_done;
  logic [7:0]  pc;
  logic        halted;
  logic        illegal_op;

  int n_asserts = 0;
  int n_fail    = 0;

  cpu_sequencer #(.PC_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .reg_sel_r0 (reg_sel_r0),
    .reg_sel_r1 (reg_sel_r1),
    .reg_sel_w0 (reg_sel_w0),
    .reg_w0_rw  (reg_w0_rw),
    .reg_r0_data(reg_r0_data),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .pc         (pc),
    .halted     (halted),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req"},    16'(imem_req),   16'h0);
    check({tag, "_addr"},   16'(imem_addr),  16'h0);
    check({tag, "_pc"},     16'(pc),         16'h0);
    check({tag, "_r0"},     16'(reg_sel_r0), 16'h0);
    check({tag, "_r1"},     16'(reg_sel_r1), 16'h0);
    check({tag, "_w0"},     16'(reg_sel_w0), 16'h0);
    check({tag, "_rw"},     16'(reg_w0_rw),  16'h0);
    check({tag, "_aluop"},  16'(alu_op),     16'h0);
    check({tag, "_start"},  16'(alu_start),  16'h0);
    check({tag, "_halted"}, 16'(halted),     16'h0);
    check({tag, "_illeg"},  16'(illegal_op), 16'h0);
  endtask

  // Branch/jump from a FETCH sample point with immediate ack: 3 cycles.
  task automatic run_ctl(input logic [15:0] instr, input logic [15:0] r0data,
                         input logic [7:0] exp_pc, input string tag);
    imem_ack = 1'b1; imem_rdata = instr;
    cyc();
    imem_ack = 1'b0;
    check({tag, "_dec_req"}, 16'(imem_req), 16'h0);
    cyc();
    reg_r0_data = r0data;
    check({tag, "_no_start"}, 16'(alu_start), 16'h0);
    cyc();
    check({tag, "_pc"},    16'(pc),        16'(exp_pc));
    check({tag, "_req"},   16'(imem_req),  16'h1);
    check({tag, "_no_rw"}, 16'(reg_w0_rw), 16'h0);
  endtask

  // R-type with immediate ack and immediate done: 4 cycles.
  task automatic run_rtype(input logic [15:0] instr, input logic [2:0] exp_w0,
                           input logic [7:0] exp_pc, input string tag);
    imem_ack = 1'b1; imem_rdata = instr;
    cyc();
    imem_ack = 1'b0;
    cyc();
    check({tag, "_start"}, 16'(alu_start), 16'h1);
    alu_done = 1'b1;
    cyc();
    alu_done = 1'b0;
    check({tag, "_rw"}, 16'(reg_w0_rw),  16'h1);
    check({tag, "_w0"}, 16'(reg_sel_w0), 16'(exp_w0));
    cyc();
    check({tag, "_pc"},    16'(pc),        16'(exp_pc));
    check({tag, "_req"},   16'(imem_req),  16'h1);
    check({tag, "_rw_end"}, 16'(reg_w0_rw), 16'h0);
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; reg_r0_data = '0; alu_done = 1'b0;
    cyc(); cyc();
    check_zero("reset");
    rst_n = 1'b1;

    // First request one cycle after the first edge out of reset.
    cyc();
    check("first_req",  16'(imem_req),  16'h1);
    check("first_addr", 16'(imem_addr), 16'h0);

    // ADD r1,r2,r3 at address 0.
    imem_ack = 1'b1; imem_rdata = 16'h014C;
    cyc();
    imem_ack = 1'b0;
    check("add_dec_req",   16'(imem_req),  16'h0);
    check("add_dec_start", 16'(alu_start), 16'h0);
    cyc();
    check("add_start", 16'(alu_start),  16'h1);
    check("add_w0",    16'(reg_sel_w0), 16'h1);
    check("add_r0",    16'(reg_sel_r0), 16'h2);
    check("add_r1",    16'(reg_sel_r1), 16'h3);
    check("add_op",    16'(alu_op),     16'h0);
    alu_done = 1'b1;
    cyc();
    alu_done = 1'b0;
    check("add_wb_rw",    16'(reg_w0_rw), 16'h1);
    check("add_wb_start", 16'(alu_start), 16'h0);
    check("add_wb_pc",    16'(pc),        16'h0);
    cyc();
    check("add_req_again", 16'(imem_req),  16'h1);
    check("add_pc",        16'(pc),        16'h1);
    check("add_rw_pulse",  16'(reg_w0_rw), 16'h0);

    // Fetch stall of 3 cycles, then ALU done 2 cycles after start.
    imem_rdata = 16'h0CB8;
    for (int i = 0; i < 3; i++) begin
      check("stall_addr", 16'(imem_addr), 16'h1);
      check("stall_req",  16'(imem_req),  16'h1);
      cyc();
    end
    imem_ack = 1'b1;
    cyc();
    imem_ack = 1'b0;
    cyc();
    check("stall_start", 16'(alu_start),  16'h1);
    check("stall_w0",    16'(reg_sel_w0), 16'h4);
    check("stall_r0",    16'(reg_sel_r0), 16'h5);
    check("stall_r1",    16'(reg_sel_r1), 16'h6);
    check("stall_op",    16'(alu_op),     16'h1);
    cyc();
    check("stall_start_once1", 16'(alu_start), 16'h0);
    check("stall_no_early_rw", 16'(reg_w0_rw), 16'h0);
    cyc();
    check("stall_start_once2", 16'(alu_start), 16'h0);
    alu_done = 1'b1;
    cyc();
    alu_done = 1'b0;
    check("stall_wb_rw", 16'(reg_w0_rw), 16'h1);
    check("stall_wb_w0", 16'(reg_sel_w0), 16'h4);
    cyc();
    check("stall_pc", 16'(pc), 16'h2);

    // Jump to 5, then BEQZ r1,-2: taken -> 4, not taken -> 5, not taken -> 6.
    run_ctl(16'h4805, 16'h0000, 8'h05, "jmp5");
    run_ctl(16'h41FE, 16'h0000, 8'h04, "beqz_taken");
    run_ctl(16'h41FE, 16'h0001, 8'h05, "beqz_nt4");
    run_ctl(16'h41FE, 16'h0001, 8'h06, "beqz_nt5");

    // PC wrap: JMP 0xFF, ADD at 0xFF -> 0x00; BEQZ +1 taken at 0xFF -> 0x01.
    run_ctl(16'h48FF, 16'h0000, 8'hFF, "jmp_ff");
    run_rtype(16'h014C, 3'd1, 8'h00, "add_wrap");
    check("wrap_addr", 16'(imem_addr), 16'h0);
    run_ctl(16'h48FF, 16'h0000, 8'hFF, "jmp_ff2");
    run_ctl(16'h4101, 16'h0000, 8'h01, "beqz_wrap");

    // Illegal opcode at pc=1.
    imem_ack = 1'b1; imem_rdata = 16'h5000;
    cyc();
    imem_ack = 1'b0;
    cyc();
`ifdef CPU_SEQUENCER_ILLEGAL_TRAP_EN
    check("ill_halted", 16'(halted),     16'h1);
    check("ill_flag",   16'(illegal_op), 16'h1);
    check("ill_pc",     16'(pc),         16'h1);
    check("ill_req",    16'(imem_req),   16'h0);
    cyc();
    check("ill_sticky", 16'(illegal_op), 16'h1);
`else
    check("ill_no_rw",  16'(reg_w0_rw),  16'h0);
    check("ill_flag",   16'(illegal_op), 16'h0);
    cyc();
    check("ill_pc",     16'(pc),         16'h2);
    check("ill_req",    16'(imem_req),   16'h1);
    check("ill_halted", 16'(halted),     16'h0);
`endif

    // Reset during a fetch: request drops without a clock edge.
    rst_n = 1'b0;
    #1;
    check("abort_req", 16'(imem_req), 16'h0);
    check_zero("abort");
    cyc();
    rst_n = 1'b1;
    cyc();
    check("post_abort_req", 16'(imem_req), 16'h1);

    // Reset asserted in WB cancels the write.
    imem_ack = 1'b1; imem_rdata = 16'h014C;
    cyc();
    imem_ack = 1'b0;
    cyc();
    alu_done = 1'b1;
    cyc();
    alu_done = 1'b0;
    check("midwb_rw_before", 16'(reg_w0_rw), 16'h1);
    rst_n = 1'b0;
    #1;
    check_zero("midwb");
    cyc();
    check("midwb_rw_held", 16'(reg_w0_rw), 16'h0);
    rst_n = 1'b1;
    cyc();
    check("midwb_pc",  16'(pc),        16'h0);
    check("midwb_req", 16'(imem_req),  16'h1);
    check("midwb_rw",  16'(reg_w0_rw), 16'h0);

    // HALT: no further requests even with ack held high.
    imem_ack = 1'b1; imem_rdata = 16'hF800;
    cyc();
    cyc();
    for (int i = 0; i < 3; i++) begin
      check("halt_halted", 16'(halted),   16'h1);
      check("halt_req",    16'(imem_req), 16'h0);
      check("halt_pc",     16'(pc),       16'h0);
      cyc();
    end
    imem_ack = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
